// File: rtl/load_unit.sv
// load_unit: multi-cycle RISC-V load unit with word-aligned bus reads,
// optional split of boundary-crossing loads, and sign/zero extension.
`default_nettype none
`timescale 1ns/1ps

module load_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_read_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              busy_o,
  output logic [1:0]        read_en_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_ack_i,
  input  logic [XLEN-1:0]   bus_rdata_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   data_o,
  output logic              misaligned_o,
  output logic              illegal_o
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, REQ1, REQ2, DONE, FAULT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] base_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              cross_q;
  logic              illegal_q;
  logic [XLEN-1:0]   lo_q, hi_q, result_q;

  logic              accept;
  logic              legal_in;
  logic              cross_in;
  logic [OFF_W+3:0]  span;
  logic [XLEN-1:0]   window;
  logic [XLEN-1:0]   ext;

  assign accept = (state == IDLE) && mem_read_i;

  // Doubleword and LWU exist only on a 64-bit datapath.
  always_comb begin
    legal_in = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_in = 1'b1;
      3'b011, 3'b110:                         legal_in = (XLEN == 64);
      default:                                legal_in = 1'b0;
    endcase
  end

  always_comb begin
    span     = (OFF_W+4)'(addr_i[OFF_W-1:0]) + ((OFF_W+4)'(1) << funct3_i[1:0]);
    cross_in = span > (OFF_W+4)'(BYTES);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!legal_in)                            state_nxt = FAULT;
          else if (cross_in && SPLIT_MISALIGNED == 0) state_nxt = FAULT;
          else                                      state_nxt = REQ1;
        end
      end
      REQ1:    if (bus_ack_i) state_nxt = cross_q ? REQ2 : DONE;
      REQ2:    if (bus_ack_i) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f3_q      <= '0;
      base_q    <= '0;
      off_q     <= '0;
      size_q    <= '0;
      cross_q   <= 1'b0;
      illegal_q <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        f3_q      <= funct3_i;
        base_q    <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        off_q     <= addr_i[OFF_W-1:0];
        size_q    <= funct3_i[1:0];
        cross_q   <= cross_in;
        illegal_q <= !legal_in;
        hi_q      <= '0;
      end
      if (state == REQ1 && bus_ack_i) lo_q <= bus_rdata_i;
      if (state == REQ2 && bus_ack_i) hi_q <= bus_rdata_i;
      if (valid_o) result_q <= data_o;
    end
  end

  // Bring the addressed bytes down to bit 0 before extending.
  assign window = XLEN'({hi_q, lo_q} >> {off_q, 3'b000});

  always_comb begin
    ext = '0;
    case (f3_q)
      3'b000:  ext = XLEN'($signed(window[7:0]));
      3'b001:  ext = XLEN'($signed(window[15:0]));
      3'b010:  ext = XLEN'($signed(window[31:0]));
      3'b100:  ext = XLEN'(window[7:0]);
      3'b101:  ext = XLEN'(window[15:0]);
      3'b110:  ext = XLEN'(window[31:0]);
      3'b011:  ext = window;
      default: ext = '0;
    endcase
  end

  always_comb begin
    busy_o       = (state != IDLE);
    read_en_o    = (state == IDLE) ? 2'b00 : size_q;
    bus_req_o    = (state == REQ1) || (state == REQ2);
    bus_addr_o   = '0;
    if (state == REQ1) bus_addr_o = base_q;
    if (state == REQ2) bus_addr_o = base_q + ADDR_W'(BYTES);
    valid_o      = (state == DONE) || (state == FAULT);
    illegal_o    = (state == FAULT) && illegal_q;
    misaligned_o = (state == FAULT) && !illegal_q;
    data_o       = result_q;
    if (state == DONE)  data_o = ext;
    if (state == FAULT) data_o = '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_load_unit.sv
// tb_load_unit: scoreboard bench for load_unit across 32-bit split, 32-bit
// non-split and 64-bit configurations sharing one stimulus/bus model.
`default_nettype none
`timescale 1ns/1ps

module tb_load_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [2:0]  mr = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [2:0]  ack = '0;
  logic [63:0] rdata = '0;

  logic        busy0, busy1, busy2, req0, req1, req2, val0, val1, val2;
  logic        mis0, mis1, mis2, ill0, ill1, ill2;
  logic [1:0]  ren0, ren1, ren2;
  logic [31:0] ba0, ba1, ba2, d0, d1;
  logic [63:0] d2;

  load_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1)) u_split32 (
    .clk_i(clk), .rst_i(rst), .mem_read_i(mr[0]), .funct3_i(funct3), .addr_i(addr),
    .busy_o(busy0), .read_en_o(ren0), .bus_req_o(req0), .bus_addr_o(ba0),
    .bus_ack_i(ack[0]), .bus_rdata_i(rdata[31:0]), .valid_o(val0), .data_o(d0),
    .misaligned_o(mis0), .illegal_o(ill0));

  load_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(0)) u_nosplit32 (
    .clk_i(clk), .rst_i(rst), .mem_read_i(mr[1]), .funct3_i(funct3), .addr_i(addr),
    .busy_o(busy1), .read_en_o(ren1), .bus_req_o(req1), .bus_addr_o(ba1),
    .bus_ack_i(ack[1]), .bus_rdata_i(rdata[31:0]), .valid_o(val1), .data_o(d1),
    .misaligned_o(mis1), .illegal_o(ill1));

  load_unit #(.XLEN(64), .ADDR_W(32), .SPLIT_MISALIGNED(1)) u_split64 (
    .clk_i(clk), .rst_i(rst), .mem_read_i(mr[2]), .funct3_i(funct3), .addr_i(addr),
    .busy_o(busy2), .read_en_o(ren2), .bus_req_o(req2), .bus_addr_o(ba2),
    .bus_ack_i(ack[2]), .bus_rdata_i(rdata), .valid_o(val2), .data_o(d2),
    .misaligned_o(mis2), .illegal_o(ill2));

  int          sel = 0;
  logic        s_busy, s_req, s_valid, s_mis, s_ill;
  logic [1:0]  s_ren;
  logic [31:0] s_baddr;
  logic [63:0] s_data;

  always_comb begin
    s_busy = busy0; s_req = req0; s_valid = val0; s_mis = mis0; s_ill = ill0;
    s_ren = ren0; s_baddr = ba0; s_data = {32'h0, d0};
    case (sel)
      1: begin
        s_busy = busy1; s_req = req1; s_valid = val1; s_mis = mis1; s_ill = ill1;
        s_ren = ren1; s_baddr = ba1; s_data = {32'h0, d1};
      end
      2: begin
        s_busy = busy2; s_req = req2; s_valid = val2; s_mis = mis2; s_ill = ill2;
        s_ren = ren2; s_baddr = ba2; s_data = d2;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [63:0] data;
    logic        mis;
    logic        ill;
    int          lat;
    logic [1:0]  ren;
    int          nreq;
    logic [31:0] addr0;
    int          t0;
    int          base;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem [logic [31:0]];
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus model: acks after wait_n cycles, checks each requested address.
  int   wait_n = 0, wcnt = 0, nacks = 0, req_idx = 0;
  logic late_ack = 1'b0;

  always @(negedge clk) begin
    ack = '0;
    if (s_req) begin
      if (sb.size() == 0) check_val("unexpected_req", 1, 0);
      else check_val("bus_addr", s_baddr, sb[0].addr0 + req_idx * ((sel == 2) ? 8 : 4));
      if (wcnt >= wait_n) begin
        ack[sel] = 1'b1;
        rdata    = mem.exists(s_baddr) ? mem[s_baddr] : 64'h0;
        wcnt     = 0;
        nacks++;
        req_idx++;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt    = 0;
      req_idx = 0;
      if (late_ack) ack[sel] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (s_valid) begin
      exp_t e;
      if (sb.size() == 0) begin
        check_val("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("data", s_data, e.data);
        check_val("misaligned", s_mis, e.mis);
        check_val("illegal", s_ill, e.ill);
        check_val("latency", cyc - e.t0, e.lat);
        if (!e.ill) check_val("read_en", s_ren, e.ren);
        check_val("bus_reads", nacks - e.base, e.nreq);
      end
    end
  end

  task automatic run_load(input int d, input logic [2:0] f3, input logic [31:0] a,
                          input int waits, input logic [63:0] ed, input logic em,
                          input logic ei, input int lat, input logic [1:0] ren,
                          input int nreq, input logic [31:0] a0, input bit pulse);
    exp_t e;
    int   n;
    sel = d; wait_n = waits; funct3 = f3; addr = a;
    e.data = ed; e.mis = em; e.ill = ei; e.lat = lat; e.ren = ren;
    e.nreq = nreq; e.addr0 = a0; e.t0 = cyc; e.base = nacks;
    sb.push_back(e);
    mr[d] = 1'b1;
    @(negedge clk);
    mr[d] = 1'b0;
    if (pulse) begin
      @(negedge clk);
      mr[d] = 1'b1; funct3 = 3'b010; addr = a + 32'h40;
      @(negedge clk);
      mr[d] = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_val("timeout", 0, 1);
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem[32'h100] = 64'hDEADBEEF;
    mem[32'h180] = 64'hDEADBEEF;
    mem[32'h200] = 64'hAA000000;
    mem[32'h204] = 64'h000000BB;
    mem[32'h300] = 64'h7F000000;
    mem[32'h008] = 64'h0123456789ABCDEF;
    mem[32'h010] = 64'h8000000000000000;
    mem[32'h018] = 64'h1122334455667788;
    mem[32'h020] = 64'h00000000000000CC;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_val("rst_ctrl", {s_busy, s_req, s_valid, s_mis, s_ill, s_ren}, 0);
      check_val("rst_bus_addr", s_baddr, 0);
      check_val("rst_data", s_data, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    late_ack = 1'b0;
    @(negedge clk);

    //       dut f3      addr          w  data                    m     i     lat ren    nrq a0            pulse
    run_load(0, 3'b010, 32'h100,       0, 64'hDEADBEEF,           1'b0, 1'b0, 2, 2'b10, 1, 32'h100, 1'b0);
    mem[32'h100] = 64'h80FF1234;
    run_load(0, 3'b000, 32'h103,       0, 64'hFFFFFF80,           1'b0, 1'b0, 2, 2'b00, 1, 32'h100, 1'b0);
    run_load(0, 3'b100, 32'h103,       0, 64'h00000080,           1'b0, 1'b0, 2, 2'b00, 1, 32'h100, 1'b0);
    run_load(0, 3'b101, 32'h102,       0, 64'h000080FF,           1'b0, 1'b0, 2, 2'b01, 1, 32'h100, 1'b0);
    run_load(0, 3'b001, 32'h102,       0, 64'hFFFF80FF,           1'b0, 1'b0, 2, 2'b01, 1, 32'h100, 1'b0);
    run_load(0, 3'b001, 32'h203,       0, 64'hFFFFBBAA,           1'b0, 1'b0, 3, 2'b01, 2, 32'h200, 1'b0);
    run_load(0, 3'b001, 32'h202,       0, 64'hFFFFAA00,           1'b0, 1'b0, 2, 2'b01, 1, 32'h200, 1'b0);
    run_load(0, 3'b011, 32'h100,       0, 64'h0,                  1'b0, 1'b1, 1, 2'b11, 0, 32'h0,   1'b0);
    run_load(0, 3'b110, 32'h100,       0, 64'h0,                  1'b0, 1'b1, 1, 2'b10, 0, 32'h0,   1'b0);
    run_load(0, 3'b010, 32'h180,       3, 64'hDEADBEEF,           1'b0, 1'b0, 5, 2'b10, 1, 32'h180, 1'b1);
    run_load(1, 3'b010, 32'h301,       0, 64'h0,                  1'b1, 1'b0, 1, 2'b10, 0, 32'h0,   1'b0);
    run_load(1, 3'b000, 32'h303,       0, 64'h0000007F,           1'b0, 1'b0, 2, 2'b00, 1, 32'h300, 1'b0);
    run_load(1, 3'b111, 32'h303,       0, 64'h0,                  1'b0, 1'b1, 1, 2'b11, 0, 32'h0,   1'b0);
    run_load(2, 3'b011, 32'h008,       0, 64'h0123456789ABCDEF,   1'b0, 1'b0, 2, 2'b11, 1, 32'h008, 1'b0);
    run_load(2, 3'b010, 32'h014,       0, 64'hFFFFFFFF80000000,   1'b0, 1'b0, 2, 2'b10, 1, 32'h010, 1'b0);
    run_load(2, 3'b110, 32'h014,       0, 64'h0000000080000000,   1'b0, 1'b0, 2, 2'b10, 1, 32'h010, 1'b0);
    run_load(2, 3'b010, 32'h01D,       1, 64'hFFFFFFFFCC112233,   1'b0, 1'b0, 5, 2'b10, 2, 32'h018, 1'b0);

    // Reset while waiting on the first bus read: no result may follow.
    begin
      exp_t e;
      sel = 0; wait_n = 1000; funct3 = 3'b010; addr = 32'h100;
      e.data = 0; e.mis = 0; e.ill = 0; e.lat = 0; e.ren = 0; e.nreq = 0;
      e.addr0 = 32'h100; e.t0 = cyc; e.base = nacks;
      sb.push_back(e);
      mr[0] = 1'b1;
      @(negedge clk);
      mr[0] = 1'b0;
      check_val("pre_rst_req", s_req, 1);
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_mid_req", s_req, 0);
      check_val("rst_mid_busy", s_busy, 0);
      sb.delete();
      rst = 1'b0;
      late_ack = 1'b1;
      repeat (5) @(negedge clk);
      late_ack = 1'b0;
      wait_n = 0;
      repeat (2) @(negedge clk);
    end

    run_load(0, 3'b010, 32'h180,       0, 64'hDEADBEEF,           1'b0, 1'b0, 2, 2'b10, 1, 32'h180, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
